// File: rtl/vga_fb_pkg.sv
// Shared constants and FSM state type for the VGA frame-buffer arbiter.
package vga_fb_pkg;

    localparam int FB_W       = 160;
    localparam int FB_H       = 120;
    localparam int SCALE_LOG2 = 2;
    localparam int ADDR_W     = 15;
    localparam int FB_DEPTH   = FB_W * FB_H;
    localparam int COL_W      = $clog2(FB_W);
    localparam int LINE_W     = $clog2(FB_H << SCALE_LOG2);

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        WAIT_LINE,
        ACTIVE
    } state_t;

endpackage

// File: rtl/vga_fb_scan_counter.sv
// Raster position counters for scan-out: sub-pixel phase, source column, line and row base address.
// Flags the RAM cycles scan-out owns and supplies the address to read in them.
module vga_fb_scan_counter
    import vga_fb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  advance,
    input  logic                  line_end,
    input  logic                  prefetch,
    input  logic                  active,
    output logic [SCALE_LOG2-1:0] sub_x,
    output logic                  scan_slot,
    output logic [ADDR_W-1:0]     scan_addr
);

    localparam logic [COL_W-1:0]      COL_LAST = COL_W'(FB_W - 1);
    localparam logic [SCALE_LOG2-1:0] SUB_LAST = '1;

    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;
    logic [ADDR_W-1:0] line_base;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sub_x     <= '0;
            col       <= '0;
            line      <= '0;
            line_base <= '0;
        end else if (line_end) begin
            sub_x <= '0;
            col   <= '0;
            line  <= line + LINE_W'(1);
            // Move to the next source row once every 2**SCALE_LOG2 raster lines
            if (line[SCALE_LOG2-1:0] == SUB_LAST)
                line_base <= line_base + ADDR_W'(FB_W);
        end else if (advance) begin
            sub_x <= sub_x + SCALE_LOG2'(1);
            if (sub_x == SUB_LAST && col != COL_LAST)
                col <= col + COL_W'(1);
        end
    end

    // The last column has no successor to fetch, so its read slot is handed to the writer
    assign scan_slot = prefetch
                     | (active & advance & (sub_x == SCALE_LOG2'(1)) & (col != COL_LAST));

    assign scan_addr = prefetch ? line_base
                                : line_base + ADDR_W'(col) + ADDR_W'(1);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares the single-port frame-buffer RAM between 4x-upscaled VGA scan-out and a pixel writer.
// Optional feature: define FBARB_STALL_CNT_EN to add the stall_cnt writer-stall counter output.
module vga_fb_arbiter
    import vga_fb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              h_display,
    input  logic              v_display,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [2:0]        wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [2:0]        mem_wdata,
    input  logic [2:0]        mem_rdata,
    output logic              r_out,
    output logic              g_out,
    output logic              b_out
`ifdef FBARB_STALL_CNT_EN
    ,output logic [15:0]      stall_cnt
`endif
);

    state_t state;
    state_t state_next;

    logic [SCALE_LOG2-1:0] sub_x;
    logic                  scan_slot;
    logic [ADDR_W-1:0]     scan_addr;
    logic                  advance;
    logic                  line_end;
    logic                  prefetch_landing;
    logic [2:0]            pix_cur;
    logic [2:0]            pix_next;
    logic                  grant;
    logic                  in_range;
    logic                  show;

    // The first displayed cycle happens in WAIT_LINE, so it already counts as sub_x=0 of column 0
    assign advance  = h_display & ((state == WAIT_LINE) | (state == ACTIVE));
    assign line_end = (state == ACTIVE) & ~h_display;

    vga_fb_scan_counter u_scan (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == IDLE),
        .advance   (advance),
        .line_end  (line_end),
        .prefetch  (state == PREFETCH),
        .active    (state == ACTIVE),
        .sub_x     (sub_x),
        .scan_slot (scan_slot),
        .scan_addr (scan_addr)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (v_display) state_next = PREFETCH;
            PREFETCH:  state_next = WAIT_LINE;
            WAIT_LINE: begin
                // Leaving on v_display low keeps blanking lines from being counted as raster lines
                if (!v_display)
                    state_next = IDLE;
                else if (h_display)
                    state_next = ACTIVE;
            end
            ACTIVE:    if (!h_display) state_next = v_display ? PREFETCH : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prefetch_landing <= 1'b0;
            pix_cur          <= '0;
            pix_next         <= '0;
        end else begin
            prefetch_landing <= (state == PREFETCH);
            if (prefetch_landing)
                pix_cur <= mem_rdata;
            else if (advance && sub_x == SCALE_LOG2'(3))
                pix_cur <= pix_next;
            if (advance && sub_x == SCALE_LOG2'(2))
                pix_next <= mem_rdata;
        end
    end

    assign grant    = wr_req & ~scan_slot & ~reset;
    assign in_range = wr_addr < ADDR_W'(FB_DEPTH);

    assign wr_ack    = grant;
    assign wr_err    = grant & ~in_range;
    assign mem_we    = grant & in_range;
    assign mem_addr  = reset ? '0 : (scan_slot ? scan_addr : wr_addr);
    assign mem_wdata = (reset || scan_slot) ? '0 : wr_data;

    assign show = ~reset & h_display & v_display & ((state == WAIT_LINE) | (state == ACTIVE));
    assign {r_out, g_out, b_out} = show ? pix_cur : 3'b000;

`ifdef FBARB_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_q <= '0;
        else if (state == IDLE && state_next == PREFETCH)
            stall_q <= '0;
        else if (wr_req && !wr_ack && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = reset ? '0 : stall_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: a RAM model, directed raster/write stimulus, and a monitor
// that checks every displayed pixel and every write acknowledge against queued expectations.
module tb_vga_fb_arbiter;
    import vga_fb_pkg::*;

    localparam int BLANK = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              h_display;
    logic              v_display;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        wr_data;
    logic              wr_ack;
    logic              wr_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [2:0]        mem_wdata;
    logic [2:0]        mem_rdata = '0;
    logic              r_out;
    logic              g_out;
    logic              b_out;
`ifdef FBARB_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        data;
        logic              err;
    } wr_exp_t;

    logic [2:0] rgb_q[$];
    wr_exp_t    wr_q[$];

    logic [2:0] ram     [0:(1 << ADDR_W) - 1];
    bit         written [0:(1 << ADDR_W) - 1];
    logic [2:0] golden  [0:FB_DEPTH - 1];

    int vectors = 0;
    int misses  = 0;
    bit writing;
    int total_stall;
    int max_stall;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .h_display (h_display),
        .v_display (v_display),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .wr_err    (wr_err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out)
`ifdef FBARB_STALL_CNT_EN
        ,.stall_cnt (stall_cnt)
`endif
    );

    // Background contents: distinctive per-address values, with the two hand-picked pixels at 0/1
    function automatic logic [2:0] pat(input int a);
        if (a == 0) return 3'b100;
        if (a == 1) return 3'b010;
        return 3'((a / FB_W) * 3 + (a % FB_W) * 5 + 1);
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : pat(int'(mem_addr));
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            misses++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pixels are owed on every displayed cycle, write checks on every acknowledge
    always @(negedge clk) begin
        if (h_display) begin
            if (rgb_q.size() == 0) begin
                vectors++;
                misses++;
                $display("[TB] FAIL rgb_unexpected: got %0d with no expectation queued", {r_out, g_out, b_out});
            end else begin
                checkOutput("rgb", {r_out, g_out, b_out}, rgb_q.pop_front());
            end
        end
        if (wr_ack) begin
            if (wr_q.size() == 0) begin
                vectors++;
                misses++;
                $display("[TB] FAIL wr_ack_unexpected: got ack for addr %0d, expected none", wr_addr);
            end else begin
                wr_exp_t e;
                e = wr_q.pop_front();
                checkOutput("wr_err", wr_err, e.err);
                checkOutput("mem_we", mem_we, !e.err);
                if (!e.err) begin
                    checkOutput("mem_addr", mem_addr, e.addr);
                    checkOutput("mem_wdata", mem_wdata, e.data);
                end
            end
        end
    end

    // One raster line: h_display high for h_len cycles, then blanking
    task automatic applyStimulus(input int line_idx, input int h_len, input int v_drop_at, input bit last);
        int base;
        base = (line_idx >> SCALE_LOG2) * FB_W;
        for (int c = 0; c < h_len; c++) begin
            if (c == v_drop_at) v_display = 1'b0;
            h_display = 1'b1;
            rgb_q.push_back(v_display ? golden[base + c / 4] : 3'b000);
            tick();
        end
        h_display = 1'b0;
        if (last) v_display = 1'b0;
        for (int c = 0; c < BLANK; c++) tick();
    endtask

    task automatic startFrame();
        v_display = 1'b1;
        for (int c = 0; c < BLANK; c++) tick();
    endtask

    task automatic doWrite(input logic [ADDR_W-1:0] addr, input logic [2:0] data, output int stalls);
        bit acked;
        wr_q.push_back('{addr, data, (int'(addr) >= FB_DEPTH)});
        wr_req  = 1'b1;
        wr_addr = addr;
        wr_data = data;
        stalls  = 0;
        acked   = 1'b0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(negedge clk);
            if (wr_ack) begin
                acked = 1'b1;
            end else begin
                stalls++;
                @(posedge clk);
                #1;
            end
        end
        if (!acked) checkOutput("wr_ack_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (acked && int'(addr) < FB_DEPTH) golden[int'(addr)] = data;
        wr_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int st;
        for (int a = 0; a < FB_DEPTH; a++) golden[a] = pat(a);
        reset     = 1'b1;
        h_display = 1'b0;
        v_display = 1'b1;
        wr_req    = 1'b1;
        wr_addr   = 15'd5;
        wr_data   = 3'b011;
        repeat (3) tick();

        // Reset state: everything quiet even with a pending write
        @(negedge clk);
        checkOutput("reset_rgb", {r_out, g_out, b_out}, 0);
        checkOutput("reset_wr_ack", wr_ack, 0);
        checkOutput("reset_mem_we", mem_we, 0);
        checkOutput("reset_mem_addr", mem_addr, 0);
        checkOutput("reset_state", 32'(dut.state), 32'(IDLE));
        @(posedge clk);
        #1;
        reset     = 1'b0;
        wr_req    = 1'b0;
        v_display = 1'b0;
        repeat (3) tick();

        // Full frame of short lines; v_display drops halfway through the last line
        $display("[TB] full frame, 480 short lines");
        startFrame();
        for (int l = 0; l < (FB_H << SCALE_LOG2); l++)
            applyStimulus(l, 8, (l == (FB_H << SCALE_LOG2) - 1) ? 4 : -1, 1'b0);
        repeat (3) tick();

        // Next frame starts again from row 0
        startFrame();
        applyStimulus(0, 8, -1, 1'b1);

        // Out-of-range write is acknowledged with an error and leaves the RAM alone
        doWrite(15'd19200, 3'b111, st);
        checkOutput("oor_stall", st, 0);
        tick();
        checkOutput("oor_ram_untouched", written[19200], 0);

        // Writer requesting continuously across a full-width line
        $display("[TB] full-width line with a saturating writer");
        total_stall = 0;
        max_stall   = 0;
        writing     = 1'b1;
        fork
            begin
                logic [ADDR_W-1:0] a;
                a = 15'd5000;
                while (writing) begin
                    doWrite(a, 3'(a), st);
                    total_stall += st;
                    if (st > max_stall) max_stall = st;
                    a = a + 15'd1;
                end
            end
            begin
                tick();
                tick();
                startFrame();
                applyStimulus(0, FB_W * 4, -1, 1'b1);
                writing = 1'b0;
            end
        join
        tick();
        checkOutput("total_stall", total_stall, 160);
        checkOutput("max_stall_le1", (max_stall <= 1), 1);
`ifdef FBARB_STALL_CNT_EN
        checkOutput("stall_cnt", stall_cnt, 160);
`endif
        for (int i = 0; i < 4; i++)
            checkOutput("ram_written", ram[5000 + i], golden[5000 + i]);

        // Reset hits in the middle of a displayed line with a write pending
        $display("[TB] reset during active line");
        startFrame();
        for (int c = 0; c < 20; c++) begin
            h_display = 1'b1;
            rgb_q.push_back(golden[c / 4]);
            tick();
        end
        reset   = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 15'd6000;
        wr_data = 3'b101;
        rgb_q.push_back(3'b000);
        @(negedge clk);
        checkOutput("midreset_wr_ack", wr_ack, 0);
        checkOutput("midreset_mem_we", mem_we, 0);
        @(posedge clk);
        #1;
        rgb_q.push_back(3'b000);
        @(negedge clk);
        checkOutput("midreset_state", 32'(dut.state), 32'(IDLE));
        @(posedge clk);
        #1;
        h_display = 1'b0;
        v_display = 1'b0;
        reset     = 1'b0;
        wr_req    = 1'b0;
        repeat (3) tick();
        checkOutput("midreset_no_write", written[6000], 0);

        startFrame();
        applyStimulus(0, 8, -1, 1'b0);
        applyStimulus(1, 8, -1, 1'b1);

        repeat (4) tick();
        checkOutput("rgb_queue_drained", rgb_q.size(), 0);
        checkOutput("wr_queue_drained", wr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
